recon_sum_4x4: RTL and testbench



---
 rtl/recon_sum_4x4.sv | 138 +++++++++++++
 tb/tb_recon_sum_4x4.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/recon_sum_4x4.sv
// Reconstruction stage: buffers one 4x4 block of residuals plus prediction,
// adds and clips each pixel, and streams the block out one 4-pixel row per handshake.
module recon_sum_4x4 #(
    parameter int PIX_W = 8,
    parameter int RES_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 start,
    output logic                 start_ready,
    input  logic                 res_zero,
    input  logic [3:0]           blk_idx_in,
    input  logic [16*RES_W-1:0]  residual_in,
    input  logic [16*PIX_W-1:0]  pred_in,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [4*PIX_W-1:0]   row_data,
    output logic [1:0]           row_idx,
    output logic [3:0]           blk_idx_out,
    output logic                 blk_done
);

    typedef enum logic {
        IDLE = 1'b0,
        OUT  = 1'b1
    } state_t;

    localparam logic signed [RES_W:0] PIX_MAX = (RES_W+1)'((1 << PIX_W) - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_row;
    logic [1:0]            w_row_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  w_last;
    logic                  w_load;

    logic [16*RES_W-1:0]   r_res;
    logic [16*PIX_W-1:0]   r_pred;
    logic                  r_res_zero;
    logic [3:0]            r_blk_idx;

    // Widening by one bit keeps res + pred exact even at the residual extremes.
    function automatic logic [PIX_W-1:0] recon_pix(
        input logic signed [RES_W-1:0] res,
        input logic        [PIX_W-1:0] pred
    );
        logic signed [RES_W:0] sum;
        sum = $signed({res[RES_W-1], res})
            + $signed({{(RES_W+1-PIX_W){1'b0}}, pred});
        if (sum[RES_W])
            recon_pix = '0;
        else if (sum > PIX_MAX)
            recon_pix = '1;
        else
            recon_pix = sum[PIX_W-1:0];
    endfunction

    always_comb begin
        w_last      = (r_state == OUT) && row_ready && (r_row == 2'd3);
        start_ready = (r_state == IDLE) || w_last;
        w_load      = ena && start && start_ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = OUT;
                    w_row_nxt   = 2'd0;
                end
            end
            OUT: begin
                if (row_ready) begin
                    // Row 3 wraps to 0, which is also the first row of a back-to-back block.
                    w_row_nxt = r_row + 2'd1;
                    if (r_row == 2'd3) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = start ? OUT : IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_row_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= 2'd0;
            r_done  <= 1'b0;
        end else if (ena) begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res      <= '0;
            r_pred     <= '0;
            r_res_zero <= 1'b0;
            r_blk_idx  <= 4'd0;
        end else if (w_load) begin
            r_res      <= residual_in;
            r_pred     <= pred_in;
            r_res_zero <= res_zero;
            r_blk_idx  <= blk_idx_in;
        end
    end

    always_comb begin
        row_data = '0;
        for (int c = 0; c < 4; c++) begin
            if (r_res_zero)
                row_data[PIX_W*c +: PIX_W] = r_pred[PIX_W*(4*int'(r_row)+c) +: PIX_W];
            else
                row_data[PIX_W*c +: PIX_W] = recon_pix(
                    $signed(r_res[RES_W*(4*int'(r_row)+c) +: RES_W]),
                    r_pred[PIX_W*(4*int'(r_row)+c) +: PIX_W]);
        end
    end

    assign row_valid   = (r_state == OUT);
    assign row_idx     = r_row;
    assign blk_idx_out = r_blk_idx;
    assign blk_done    = r_done;

endmodule

// File: tb/tb_recon_sum_4x4.sv
// Scoreboard bench for recon_sum_4x4: expected rows are queued at load time
// and compared whenever a row is handed downstream.
module tb_recon_sum_4x4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         start;
    logic         start_ready;
    logic         res_zero;
    logic [3:0]   blk_idx_in;
    logic [255:0] residual_in;
    logic [127:0] pred_in;
    logic         row_valid;
    logic         row_ready;
    logic [31:0]  row_data;
    logic [1:0]   row_idx;
    logic [3:0]   blk_idx_out;
    logic         blk_done;

    always #5 clk = ~clk;

    recon_sum_4x4 #(.PIX_W(8), .RES_W(16)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .start(start), .start_ready(start_ready), .res_zero(res_zero),
        .blk_idx_in(blk_idx_in), .residual_in(residual_in), .pred_in(pred_in),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_idx(row_idx), .blk_idx_out(blk_idx_out), .blk_done(blk_done)
    );

    typedef struct {
        logic [3:0]  blk;
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t               sb[$];
    int                 n_vec  = 0;
    int                 n_err  = 0;
    int                 n_done = 0;
    logic signed [15:0] res_a[16];
    logic [7:0]         pred_a[16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_pix(input logic signed [15:0] r, input logic [7:0] p, input bit rz);
        int s;
        if (rz) return p;
        s = int'(r) + int'(p);
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return s[7:0];
    endfunction

    task automatic load(input logic [3:0] blk, input bit rz);
        exp_t e;
        bit   ok = 0;
        for (int i = 0; i < 16; i++) begin
            residual_in[16*i +: 16] = res_a[i];
            pred_in[8*i +: 8]       = pred_a[i];
        end
        for (int r = 0; r < 4; r++) begin
            e.blk = blk;
            e.idx = 2'(r);
            for (int c = 0; c < 4; c++)
                e.data[8*c +: 8] = ref_pix(res_a[4*r+c], pred_a[4*r+c], rz);
            sb.push_back(e);
        end
        res_zero   = rz;
        blk_idx_in = blk;
        start      = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (start_ready && ena && !rst) ok = 1;
        end
        if (!ok) chk("load_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (row_valid && k < 50) begin
            #10;
            k++;
        end
        if (row_valid) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic set_scen1();
        for (int r = 0; r < 4; r++) begin
            res_a[4*r+0] = 16'(r);
            res_a[4*r+1] = -16'(r);
            res_a[4*r+2] = 16'sd10;
            res_a[4*r+3] = -16'sd10;
        end
        for (int i = 0; i < 16; i++) pred_a[i] = 8'd100;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) begin
            res_a[i]  = 16'($urandom_range(0, 600)) - 16'sd300;
            pred_a[i] = 8'($urandom);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ena && row_valid && row_ready) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("row_data", row_data, e.data);
                chk("row_idx", 32'(row_idx), 32'(e.idx));
                chk("blk_idx", 32'(blk_idx_out), 32'(e.blk));
            end
        end
        if (!rst && ena && blk_done) n_done++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap;
        rst = 1'b1; ena = 1'b1; start = 1'b0; res_zero = 1'b0; row_ready = 1'b0;
        blk_idx_in = 4'd0; residual_in = '0; pred_in = '0;
        #3;
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_row_valid", 32'(row_valid), 32'd0);
        chk("rst_row_idx", 32'(row_idx), 32'd0);
        chk("rst_blk_idx", 32'(blk_idx_out), 32'd0);
        chk("rst_blk_done", 32'(blk_done), 32'd0);
        chk("rst_row_data", row_data, 32'd0);
        @(posedge clk); #2 rst = 1'b0; row_ready = 1'b1;

        // Scenario 1: nominal block, rows on four consecutive cycles
        set_scen1();
        load(4'd1, 1'b0);
        chk("s1_valid_lat", 32'(row_valid), 32'd1);
        chk("s1_idx0", 32'(row_idx), 32'd0);
        chk("s1_blk", 32'(blk_idx_out), 32'd1);
        #10 chk("s1_idx1", 32'(row_idx), 32'd1);
        #10 chk("s1_idx2", 32'(row_idx), 32'd2);
        chk("s1_row2", row_data, {8'd90, 8'd110, 8'd98, 8'd102});
        #10 chk("s1_idx3", 32'(row_idx), 32'd3);
        #10 chk("s1_done", 32'(blk_done), 32'd1);
        chk("s1_valid_end", 32'(row_valid), 32'd0);
        chk("s1_start_ready", 32'(start_ready), 32'd1);
        #10 chk("s1_done_clr", 32'(blk_done), 32'd0);

        // Scenario 2: clip extremes, then freeze while blk_done is pending
        set_random();
        pred_a[0] = 8'd250; res_a[0] = 16'sd20;
        pred_a[1] = 8'd5;   res_a[1] = -16'sd20;
        pred_a[2] = 8'd0;   res_a[2] = 16'sh7FFF;
        pred_a[3] = 8'd255; res_a[3] = 16'sh8000;
        load(4'd2, 1'b0);
        chk("s2_row0", row_data, {8'd0, 8'd255, 8'd0, 8'd255});
        #40 chk("s2_done", 32'(blk_done), 32'd1);
        ena = 1'b0;
        #20 chk("s2_done_frozen", 32'(blk_done), 32'd1);
        ena = 1'b1;
        #10 chk("s2_done_clr", 32'(blk_done), 32'd0);

        // Scenario 3: res_zero passes prediction through untouched
        for (int i = 0; i < 16; i++) begin
            res_a[i]  = 16'sh7FFF;
            pred_a[i] = 8'(i);
        end
        load(4'd3, 1'b1);
        chk("s3_row0", row_data, 32'h03020100);
        wait_idle();

        // Scenario 4: backpressure on row 1, then ena freeze on row 2
        set_random();
        load(4'd8, 1'b0);
        #10 row_ready = 1'b0;
        snap = row_data;
        for (int k = 0; k < 3; k++) begin
            #10;
            chk("s4_hold_data", row_data, snap);
            chk("s4_hold_idx", 32'(row_idx), 32'd1);
            chk("s4_hold_blk", 32'(blk_idx_out), 32'd8);
        end
        row_ready = 1'b1;
        #10 chk("s4_idx2", 32'(row_idx), 32'd2);
        ena = 1'b0;
        #20 chk("s4_ena_idx", 32'(row_idx), 32'd2);
        chk("s4_ena_valid", 32'(row_valid), 32'd1);
        ena = 1'b1;
        wait_idle();

        // Scenario 5: ignored early start, then back-to-back blocks 4 and 5
        set_random();
        load(4'd4, 1'b0);
        #10 chk("s5_sr_r1", 32'(start_ready), 32'd0);
        blk_idx_in = 4'd9; start = 1'b1;
        #10 start = 1'b0;
        chk("s5_blk_kept", 32'(blk_idx_out), 32'd4);
        set_random();
        load(4'd5, 1'b0);
        chk("s5_b2b_valid", 32'(row_valid), 32'd1);
        chk("s5_b2b_idx", 32'(row_idx), 32'd0);
        chk("s5_b2b_blk", 32'(blk_idx_out), 32'd5);
        chk("s5_b2b_done", 32'(blk_done), 32'd1);
        #10 chk("s5_done_once", 32'(blk_done), 32'd0);
        wait_idle();

        // Scenario 6: asynchronous reset mid-block, then a clean reload
        set_random();
        load(4'd6, 1'b0);
        begin
            int k = 0;
            while (row_idx != 2'd2 && k < 10) begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("s6_r2", 32'(row_idx), 32'd2);
        rst = 1'b1;
        #1;
        chk("s6_valid", 32'(row_valid), 32'd0);
        chk("s6_done", 32'(blk_done), 32'd0);
        chk("s6_start_ready", 32'(start_ready), 32'd1);
        chk("s6_row_data", row_data, 32'd0);
        sb.delete();
        rst = 1'b0;
        set_scen1();
        load(4'd7, 1'b0);
        chk("s6_reload_idx0", 32'(row_idx), 32'd0);
        #20 chk("s6_reload_row2", row_data, {8'd90, 8'd110, 8'd98, 8'd102});
        #20 chk("s6_reload_done", 32'(blk_done), 32'd1);
        wait_idle();
        #20;

        chk("blk_done_count", 32'(n_done), 32'd7);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
